// File: rtl/fir_pkg.sv
// fir_pkg: shared register offsets, AXI response codes and feeder types
package fir_pkg;
  localparam logic [31:0] FIR_REG_SAMPLE = 32'h0;
  localparam logic [31:0] FIR_REG_CONFIG = 32'h4;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  typedef enum logic [1:0] {IDLE, WRITE, RESP} feeder_state_t;
  typedef struct packed {
    logic        cfg;
    logic [31:0] data;
  } fifo_entry_t;
endpackage

// File: rtl/fir_feeder_fifo.sv
// fir_feeder_fifo: synchronous FIFO with registered occupancy and full/empty flags
module fir_feeder_fifo #(
  parameter int W = 33,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign full = count == FULL_COUNT;
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign pop_data = mem[rd_ptr];
  // storage array needs no reset; only occupied slots are ever read
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= push_data;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
endmodule

// File: rtl/fir_axil_feeder.sv
// fir_axil_feeder: turns stream words into single AXI4-Lite writes to the FIR register block
module fir_axil_feeder
  import fir_pkg::*;
#(
  parameter int C_M00_AXI_ADDR_WIDTH = 32,
  parameter int C_M00_AXI_DATA_WIDTH = 32,
  parameter logic [C_M00_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = '0,
  parameter int C_FIFO_DEPTH = 4
) (
  input  logic                              m00_axi_aclk,
  input  logic                              m00_axi_aresetn,
  input  logic [C_M00_AXI_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                              s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  output logic [C_M00_AXI_ADDR_WIDTH-1:0]   m00_axi_awaddr,
  output logic [2:0]                        m00_axi_awprot,
  output logic                              m00_axi_awvalid,
  input  logic                              m00_axi_awready,
  output logic [C_M00_AXI_DATA_WIDTH-1:0]   m00_axi_wdata,
  output logic [C_M00_AXI_DATA_WIDTH/8-1:0] m00_axi_wstrb,
  output logic                              m00_axi_wvalid,
  input  logic                              m00_axi_wready,
  input  logic [1:0]                        m00_axi_bresp,
  input  logic                              m00_axi_bvalid,
  output logic                              m00_axi_bready,
  output logic                              busy,
  output logic                              err_flag,
  input  logic                              err_clear,
  output logic [15:0]                       wr_count
);
  feeder_state_t state;
  fifo_entry_t head, tail;
  logic full, empty, ready_en, pop, aw_done, w_done, aw_hs, w_hs, b_hs;
  assign tail = {s_axis_tuser, 32'(s_axis_tdata)};
  assign s_axis_tready = ready_en && !full;
  assign pop = state == IDLE && !empty;
  assign aw_hs = m00_axi_awvalid && m00_axi_awready;
  assign w_hs = m00_axi_wvalid && m00_axi_wready;
  assign b_hs = m00_axi_bvalid && m00_axi_bready;
  assign busy = state != IDLE || !empty;
  assign m00_axi_awprot = 3'b000;
  fir_feeder_fifo #(.W($bits(fifo_entry_t)), .DEPTH(C_FIFO_DEPTH)) u_fifo (
    .clk(m00_axi_aclk),
    .rst_n(m00_axi_aresetn),
    .push(s_axis_tvalid && s_axis_tready),
    .push_data(tail),
    .pop(pop),
    .pop_data(head),
    .full(full),
    .empty(empty)
  );
  // keeps tready low while reset is held and for the first edge after release
  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn)
    if (!m00_axi_aresetn) ready_en <= 1'b0;
    else ready_en <= 1'b1;
  // an error response in the same cycle as a clear keeps the flag set
  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn)
    if (!m00_axi_aresetn) err_flag <= 1'b0;
    else err_flag <= (b_hs && m00_axi_bresp != AXI_RESP_OKAY) ? 1'b1 : err_clear ? 1'b0 : err_flag;
  // write sequencer: pop, present AW and W independently, then wait for B
  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn)
    if (!m00_axi_aresetn) begin
      state <= IDLE;
      m00_axi_awaddr <= '0;
      m00_axi_awvalid <= 1'b0;
      m00_axi_wdata <= '0;
      m00_axi_wstrb <= '0;
      m00_axi_wvalid <= 1'b0;
      m00_axi_bready <= 1'b0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      wr_count <= '0;
    end else begin
      case (state)
        IDLE: if (!empty) begin
          m00_axi_awaddr <= C_BASE_ADDR + (head.cfg ? C_M00_AXI_ADDR_WIDTH'(FIR_REG_CONFIG)
                                                    : C_M00_AXI_ADDR_WIDTH'(FIR_REG_SAMPLE));
          m00_axi_wdata <= C_M00_AXI_DATA_WIDTH'(head.data);
          m00_axi_wstrb <= '1;
          m00_axi_awvalid <= 1'b1;
          m00_axi_wvalid <= 1'b1;
          aw_done <= 1'b0;
          w_done <= 1'b0;
          state <= WRITE;
        end
        WRITE: begin
          if (aw_hs) m00_axi_awvalid <= 1'b0;
          if (w_hs) begin
            m00_axi_wvalid <= 1'b0;
            m00_axi_wstrb <= '0;
          end
          aw_done <= aw_done || aw_hs;
          w_done <= w_done || w_hs;
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            m00_axi_bready <= 1'b1;
            state <= RESP;
          end
        end
        RESP: if (b_hs) begin
          m00_axi_bready <= 1'b0;
          aw_done <= 1'b0;
          w_done <= 1'b0;
          wr_count <= wr_count == 16'hFFFF ? wr_count : wr_count + 16'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_fir_axil_feeder.sv
// tb_fir_axil_feeder: vector table, directed corner cases and random traffic against a queue-based model
module tb_fir_axil_feeder;
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [31:0] tdata = '0, awaddr, wdata;
  logic tuser = 1'b0, tvalid = 1'b0, tready, awvalid, wvalid, bready, busy, err_flag;
  logic awready = 1'b0, wready = 1'b0, bvalid = 1'b0, err_clear = 1'b0;
  logic [1:0] bresp = 2'b00, resp_sel = 2'b00;
  logic [2:0] awprot;
  logic [3:0] wstrb;
  logic [15:0] wr_count;
  int checks = 0, errors = 0;
  int aw_dly = 0, w_dly = 0, b_dly = 0;

  fir_axil_feeder dut (
    .m00_axi_aclk(clk), .m00_axi_aresetn(rst_n),
    .s_axis_tdata(tdata), .s_axis_tuser(tuser), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
    .m00_axi_awaddr(awaddr), .m00_axi_awprot(awprot), .m00_axi_awvalid(awvalid), .m00_axi_awready(awready),
    .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb), .m00_axi_wvalid(wvalid), .m00_axi_wready(wready),
    .m00_axi_bresp(bresp), .m00_axi_bvalid(bvalid), .m00_axi_bready(bready),
    .busy(busy), .err_flag(err_flag), .err_clear(err_clear), .wr_count(wr_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, want, $time);
    end
  endtask

  // reference model: every accepted word must appear once, in order, on AW and W
  logic [31:0] exp_aw[$], exp_w[$];
  int acc_n = 0, aw_n = 0, w_n = 0, b_n = 0, aw_cyc = 0, w_cyc = 0, last_aw_cyc = 0, last_w_cyc = 0;
  logic [31:0] last_awaddr = '0, last_wdata = '0, awaddr_q = '0, wdata_q = '0;
  logic [15:0] mdl_cnt = '0;
  logic mdl_err = 1'b0, live = 1'b0, awv_q = 1'b0, awr_q = 1'b0, wv_q = 1'b0, wr_q = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_aw.delete(); exp_w.delete();
      acc_n = 0; aw_n = 0; w_n = 0; b_n = 0; aw_cyc = 0; w_cyc = 0;
      mdl_cnt = '0; mdl_err = 1'b0; live = 1'b0;
      awv_q = 1'b0; awr_q = 1'b0; wv_q = 1'b0; wr_q = 1'b0;
    end else begin
      live = 1'b1;
      if (tvalid && tready) begin
        acc_n++;
        exp_aw.push_back(tuser ? 32'h4 : 32'h0);
        exp_w.push_back(tdata);
      end
      if (awv_q && !awr_q) chk("aw_stable", {awvalid, awaddr}, {1'b1, awaddr_q});
      if (wv_q && !wr_q) chk("w_stable", {wvalid, wstrb, wdata}, {1'b1, 4'hF, wdata_q});
      if (awvalid) aw_cyc++;
      if (wvalid) w_cyc++;
      if (awvalid && awready) begin
        chk("aw_expected", exp_aw.size() > 0, 1);
        if (exp_aw.size() > 0) chk("aw_addr", awaddr, exp_aw.pop_front());
        aw_n++; last_aw_cyc = aw_cyc; aw_cyc = 0; last_awaddr = awaddr;
      end
      if (wvalid && wready) begin
        chk("w_expected", exp_w.size() > 0, 1);
        if (exp_w.size() > 0) chk("w_data", {wstrb, wdata}, {4'hF, exp_w.pop_front()});
        w_n++; last_w_cyc = w_cyc; w_cyc = 0; last_wdata = wdata;
      end
      if (bvalid && bready) begin
        b_n++;
        if (mdl_cnt != 16'hFFFF) mdl_cnt++;
      end
      mdl_err = (bvalid && bready && bresp != 2'b00) ? 1'b1 : err_clear ? 1'b0 : mdl_err;
      awv_q = awvalid; awr_q = awready; awaddr_q = awaddr;
      wv_q = wvalid; wr_q = wready; wdata_q = wdata;
    end
  end

  // slave: ready after a programmable wait, response once both AW and W are in
  int aw_c = 0, w_c = 0, b_c = 0;
  logic b_pend;
  always @(negedge clk) begin
    if (!rst_n) begin
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; aw_c = 0; w_c = 0; b_c = 0;
    end else begin
      aw_c = awvalid ? aw_c + 1 : 0;
      awready = awvalid && aw_c > aw_dly;
      w_c = wvalid ? w_c + 1 : 0;
      wready = wvalid && w_c > w_dly;
      b_pend = (aw_n < w_n ? aw_n : w_n) > b_n;
      b_c = b_pend ? b_c + 1 : 0;
      bvalid = b_pend && b_c > b_dly;
      bresp = bvalid ? resp_sel : 2'b00;
    end
  end

  // occupancy and activity derived from counted pushes, starts and responses
  int started = 0, lows = 0;
  logic awv_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst_n || !live) begin
      started = 0; awv_prev = 1'b0;
    end else begin
      if (awvalid && !awv_prev) started++;
      awv_prev = awvalid;
      if (!tready) lows++;
      chk("tready", tready, (acc_n - started) < DEPTH);
      chk("busy", busy, (acc_n - started) > 0 || started != b_n);
      chk("wr_count", wr_count, mdl_cnt);
      chk("err_flag", err_flag, mdl_err);
      chk("wstrb", wstrb, wvalid ? 4'hF : 4'h0);
      chk("awprot", awprot, 0);
    end
  end

  task automatic push(input logic [31:0] d, input logic u);
    logic ok;
    int n = 0;
    @(negedge clk);
    tdata = d; tuser = u; tvalid = 1'b1;
    forever begin
      ok = tready;
      @(posedge clk);
      n++;
      if (ok || n > 200) break;
      @(negedge clk);
    end
    chk("push_accept", ok, 1);
  endtask

  task automatic stop();
    @(negedge clk);
    tvalid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    do begin
      @(negedge clk);
      tvalid = 1'b0;
      n++;
    end while (busy && n < 500);
    chk("idle_reached", busy, 0);
  endtask

  typedef struct {
    logic [31:0] data; logic user; int aw_d; int w_d; int b_d; logic [1:0] resp;
    logic [31:0] exp_addr; logic [15:0] exp_cnt; logic exp_err; int exp_awc; int exp_wc;
  } vec_t;
  vec_t tv[8];

  initial begin
    int n;
    logic [15:0] c0;
    tv[0] = '{32'hABCD1234, 1'b0, 0, 0, 0, 2'b00, 32'h0, 16'd1, 1'b0, 1, 1};
    tv[1] = '{32'h00000055, 1'b1, 0, 0, 0, 2'b00, 32'h4, 16'd2, 1'b0, 1, 1};
    tv[2] = '{32'h00000001, 1'b0, 0, 0, 0, 2'b00, 32'h0, 16'd3, 1'b0, 1, 1};
    tv[3] = '{32'hDEAD0003, 1'b1, 3, 0, 0, 2'b00, 32'h4, 16'd4, 1'b0, 4, 1};
    tv[4] = '{32'h00000005, 1'b0, 0, 3, 2, 2'b00, 32'h0, 16'd5, 1'b0, 1, 4};
    tv[5] = '{32'h00000006, 1'b1, 2, 2, 0, 2'b00, 32'h4, 16'd6, 1'b0, 3, 3};
    tv[6] = '{32'h00000077, 1'b0, 0, 0, 1, 2'b10, 32'h0, 16'd7, 1'b1, 1, 1};
    tv[7] = '{32'h00000088, 1'b1, 1, 0, 0, 2'b00, 32'h4, 16'd8, 1'b1, 2, 1};
    #1;
    chk("rst_awvalid", awvalid, 0); chk("rst_wvalid", wvalid, 0); chk("rst_bready", bready, 0);
    chk("rst_busy", busy, 0); chk("rst_err", err_flag, 0); chk("rst_awaddr", awaddr, 0);
    chk("rst_wdata", wdata, 0); chk("rst_wstrb", wstrb, 0); chk("rst_count", wr_count, 0);
    chk("rst_tready", tready, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("tready_after_rst", tready, 1);

    for (int i = 0; i < 8; i++) begin
      aw_dly = tv[i].aw_d; w_dly = tv[i].w_d; b_dly = tv[i].b_d; resp_sel = tv[i].resp;
      push(tv[i].data, tv[i].user);
      wait_idle(n);
      chk("vec_awaddr", last_awaddr, tv[i].exp_addr);
      chk("vec_wdata", last_wdata, tv[i].data);
      chk("vec_count", wr_count, tv[i].exp_cnt);
      chk("vec_err", err_flag, tv[i].exp_err);
      chk("vec_aw_cycles", last_aw_cyc, tv[i].exp_awc);
      chk("vec_w_cycles", last_w_cyc, tv[i].exp_wc);
      if (tv[i].aw_d == 0 && tv[i].w_d == 0 && tv[i].b_d == 0) chk("vec_busy_drop", n <= 4, 1);
    end

    aw_dly = 0; w_dly = 0; b_dly = 0; resp_sel = 2'b00;
    @(negedge clk); err_clear = 1'b1;
    @(negedge clk); err_clear = 1'b0;
    chk("err_clear", err_flag, 0);

    resp_sel = 2'b10; b_dly = 2; c0 = wr_count;
    push(32'h99, 1'b0);
    @(negedge clk); tvalid = 1'b0; err_clear = 1'b1;
    n = 0;
    while (wr_count == c0 && n < 50) begin @(negedge clk); n++; end
    chk("err_set_wins", err_flag, 1);
    chk("err_write_counted", wr_count, c0 + 16'd1);
    @(negedge clk); err_clear = 1'b0;
    chk("err_cleared_after", err_flag, 0);
    wait_idle(n);

    resp_sel = 2'b00; b_dly = 5; c0 = wr_count; lows = 0;
    for (int v = 1; v <= 6; v++) push(32'(v), 1'(v % 2));
    stop();
    wait_idle(n);
    chk("bp_count", wr_count, c0 + 16'd6);
    chk("bp_tready_low_seen", lows > 0, 1);
    chk("bp_no_loss", exp_aw.size() + exp_w.size(), 0);

    for (int i = 0; i < 40; i++) begin
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 4);
      resp_sel = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      push($urandom, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        tvalid = 1'b0;
        err_clear = $urandom_range(0, 3) == 0;
      end
    end
    @(negedge clk); tvalid = 1'b0; err_clear = 1'b0;
    wait_idle(n);
    chk("rand_drained", exp_aw.size() + exp_w.size(), 0);
    chk("rand_count", wr_count, mdl_cnt);

    aw_dly = 50; w_dly = 0; b_dly = 0; resp_sel = 2'b00;
    push(32'h1, 1'b0); push(32'h2, 1'b1); push(32'h3, 1'b0);
    @(negedge clk); tvalid = 1'b0;
    chk("pre_rst_awvalid", awvalid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_awvalid", awvalid, 0); chk("midrst_wvalid", wvalid, 0); chk("midrst_bready", bready, 0);
    chk("midrst_busy", busy, 0); chk("midrst_count", wr_count, 0); chk("midrst_tready", tready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; aw_dly = 0;
    repeat (20) @(negedge clk);
    chk("post_rst_no_aw", aw_n, 0);
    chk("post_rst_tready", tready, 1);
    chk("post_rst_busy", busy, 0);
    push(32'h00C0FFEE, 1'b1);
    wait_idle(n);
    chk("post_rst_addr", last_awaddr, 32'h4);
    chk("post_rst_data", last_wdata, 32'h00C0FFEE);
    chk("post_rst_count", wr_count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
